stream_in_matrix_ping_pong: RTL and testbench

//  Collects a row-major serial element stream into full R x C matrices using two banks.
//  One bank fills while the other presents a complete matrix to the consumer.

---
 rtl/matrix_stream_pkg.sv | 26 ++
 rtl/matrix_bank.sv | 30 +++
 rtl/stream_in_matrix_ping_pong.sv | 113 +++++++++++
 tb/tb_stream_in_matrix_ping_pong.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_pkg.sv
// Shared helpers for the matrix stream blocks: element counts, index widths and
// linear-index to row/column decoding.
package matrix_stream_pkg;

   typedef struct packed {
      int unsigned row;
      int unsigned col;
   } rc_t;

   function automatic int unsigned elements(input int unsigned r, input int unsigned c);
      return r * c;
   endfunction

   // Counter width for n states, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic rc_t idx_to_rc(input int unsigned idx, input int unsigned c);
      rc_t rc;
      rc.row = idx / c;
      rc.col = idx % c;
      return rc;
   endfunction

endpackage

// File: rtl/matrix_bank.sv
// R x C element register array: single-element write port, full parallel read.
module matrix_bank
   import matrix_stream_pkg::*;
#(
   parameter int unsigned BITS = 8,
   parameter int unsigned R    = 3,
   parameter int unsigned C    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we,
   input  logic [idx_w(R)-1:0]    row,
   input  logic [idx_w(C)-1:0]    col,
   input  logic [BITS-1:0]        data,
   output logic [BITS-1:0]        q [R][C]
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(R); r++) begin
            for (int c = 0; c < int'(C); c++) begin
               q[r][c] <= '0;
            end
         end
      end else if (we) begin
         q[row][col] <= data;
      end
   end

endmodule

// File: rtl/stream_in_matrix_ping_pong.sv
// Collects a row-major element stream into whole R x C matrices; one bank fills while
// the other holds a complete matrix for the consumer.
module stream_in_matrix_ping_pong
   import matrix_stream_pkg::*;
#(
   parameter int unsigned BITS = 8,
   parameter int unsigned R    = 3,
   parameter int unsigned C    = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_sof,
   input  logic [BITS-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] m [R][C],
   output logic            sof_drop
);

   localparam int unsigned ELEMENTS = elements(R, C);
   localparam int unsigned IDX_W    = idx_w(ELEMENTS);
   localparam int unsigned ROW_W    = idx_w(R);
   localparam int unsigned COL_W    = idx_w(C);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENTS - 1);

   logic [IDX_W-1:0] idx_q, idx_d, wr_idx;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [1:0]       full_q, full_d;
   logic             sof_drop_q, sof_drop_d;
   logic             accept, rel, last;
   rc_t              rc;
   logic [ROW_W-1:0] wr_row;
   logic [COL_W-1:0] wr_col;
   logic [BITS-1:0]  bank_q [2][R][C];

   always_comb begin
      in_ready   = !full_q[wr_bank_q];
      accept     = in_valid & in_ready;
      out_valid  = full_q[rd_bank_q];
      rel        = out_valid & out_ready;
      // A start-of-matrix element always lands at [0][0], abandoning any partial fill.
      wr_idx     = in_sof ? '0 : idx_q;
      last       = (wr_idx == LAST_IDX);
      rc         = idx_to_rc(32'(wr_idx), C);
      wr_row     = ROW_W'(rc.row);
      wr_col     = COL_W'(rc.col);

      idx_d      = idx_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      full_d     = full_q;
      sof_drop_d = 1'b0;

      if (rel) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
      if (accept) begin
         idx_d      = last ? '0 : wr_idx + 1'b1;
         sof_drop_d = in_sof && (idx_q != '0);
         if (last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_q     <= '0;
         sof_drop_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         sof_drop_q <= sof_drop_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      matrix_bank #(
         .BITS (BITS),
         .R    (R),
         .C    (C)
      ) u_bank (
         .clk   (clk),
         .rst_n (rst_n),
         .we    (accept && (wr_bank_q == 1'(b))),
         .row   (wr_row),
         .col   (wr_col),
         .data  (in_data),
         .q     (bank_q[b])
      );
   end

   always_comb begin
      for (int r = 0; r < int'(R); r++) begin
         for (int c = 0; c < int'(C); c++) begin
            m[r][c] = bank_q[rd_bank_q][r][c];
         end
      end
   end

   assign sof_drop = sof_drop_q;

endmodule

// File: tb/tb_stream_in_matrix_ping_pong.sv
// Directed bench for the ping-pong matrix collector (BITS=8, R=3, C=3).
module tb_stream_in_matrix_ping_pong;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_sof;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] m [3][3];
   logic       sof_drop;

   int checks = 0;
   int errors = 0;

   stream_in_matrix_ping_pong #(
      .BITS (8),
      .R    (3),
      .C    (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .m         (m),
      .sof_drop  (sof_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] mflat();
      logic [71:0] f;
      for (int i = 0; i < 9; i++) f[i*8 +: 8] = m[i/3][i%3];
      return f;
   endfunction

   function automatic logic [71:0] exp_m(input int base);
      logic [71:0] f;
      for (int i = 0; i < 9; i++) f[i*8 +: 8] = 8'(base + i);
      return f;
   endfunction

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input logic s);
      chk("in_ready before accept", 72'(in_ready), 72'(1));
      in_valid = 1'b1;
      in_data  = 8'(d);
      in_sof   = s;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      tick();
   endtask

   initial begin
      int pulses, drops, spacing_bad, last_pulse, saw_valid;
      logic [71:0] first_m, last_m;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #1;
      chk("reset out_valid", 72'(out_valid), 72'(0));
      chk("reset in_ready", 72'(in_ready), 72'(1));
      chk("reset m", mflat(), 72'(0));
      chk("reset sof_drop", 72'(sof_drop), 72'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Single matrix 1..9 with the consumer always ready.
      for (int i = 0; i < 9; i++) send(1 + i, i == 0);
      chk("t1 out_valid", 72'(out_valid), 72'(1));
      chk("t1 m", mflat(), exp_m(1));
      idle();
      chk("t1 out_valid one cycle", 72'(out_valid), 72'(0));

      // Fill both banks with the consumer stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(10 + i, i == 0);
      chk("t2 out_valid after 9", 72'(out_valid), 72'(1));
      chk("t2 m 10..18", mflat(), exp_m(10));
      for (int i = 0; i < 9; i++) send(19 + i, i == 0);
      chk("t2 in_ready both full", 72'(in_ready), 72'(0));
      in_valid = 1'b1;
      in_data  = 8'd28;
      in_sof   = 1'b0;
      tick();
      tick();
      chk("t2 in_ready stalled", 72'(in_ready), 72'(0));
      chk("t2 m stable while stalled", mflat(), exp_m(10));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2 out_valid second bank", 72'(out_valid), 72'(1));
      chk("t2 m 19..27", mflat(), exp_m(19));
      chk("t2 in_ready after release", 72'(in_ready), 72'(1));
      out_ready = 1'b1;
      tick();
      chk("t2 drained", 72'(out_valid), 72'(0));

      // Partial matrix abandoned by a new start-of-matrix.
      saw_valid = 0;
      for (int i = 0; i < 4; i++) begin
         send(1 + i, i == 0);
         if (out_valid || sof_drop) saw_valid++;
      end
      send(50, 1'b1);
      chk("t3 sof_drop pulse", 72'(sof_drop), 72'(1));
      for (int i = 0; i < 8; i++) begin
         send(51 + i, 1'b0);
         if (i == 0) chk("t3 sof_drop single", 72'(sof_drop), 72'(0));
      end
      chk("t3 no early matrix", 72'(saw_valid), 72'(0));
      chk("t3 out_valid", 72'(out_valid), 72'(1));
      chk("t3 m 50..58", mflat(), exp_m(50));
      idle();
      chk("t3 no second matrix", 72'(out_valid), 72'(0));

      // Continuous stream 0..44.
      pulses = 0; drops = 0; spacing_bad = 0; last_pulse = -1;
      first_m = '0; last_m = '0;
      for (int i = 0; i < 45; i++) begin
         if (!in_ready) drops++;
         in_valid = 1'b1;
         in_data  = 8'(i);
         in_sof   = (i % 9) == 0;
         tick();
         if (out_valid) begin
            pulses++;
            if (last_pulse >= 0 && (i + 1 - last_pulse) != 9) spacing_bad++;
            if (pulses == 1) first_m = mflat();
            last_m     = mflat();
            last_pulse = i + 1;
         end
      end
      idle();
      chk("t4 in_ready drops", 72'(drops), 72'(0));
      chk("t4 matrix count", 72'(pulses), 72'(5));
      chk("t4 pulse spacing", 72'(spacing_bad), 72'(0));
      chk("t4 first m", first_m, exp_m(0));
      chk("t4 last m", last_m, exp_m(36));
      chk("t4 drained", 72'(out_valid), 72'(0));

      // Reset with one bank full and another partially filled.
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(100 + i, i == 0);
      for (int i = 0; i < 5; i++) send(109 + i, 1'b0);
      chk("t5 full before reset", 72'(out_valid), 72'(1));
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t5 async out_valid", 72'(out_valid), 72'(0));
      chk("t5 async in_ready", 72'(in_ready), 72'(1));
      chk("t5 async m", mflat(), 72'(0));
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("t5 no glitch", 72'(out_valid), 72'(0));
      for (int i = 0; i < 9; i++) send(200 + i, i == 0);
      chk("t5 out_valid", 72'(out_valid), 72'(1));
      chk("t5 m 200..208", mflat(), exp_m(200));
      idle();

      // Completion into one bank and release of the other on the same edge.
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(60 + i, i == 0);
      for (int i = 0; i < 8; i++) send(70 + i, i == 0);
      chk("t6 m before swap", mflat(), exp_m(60));
      out_ready = 1'b1;
      send(78, 1'b0);
      chk("t6 out_valid held", 72'(out_valid), 72'(1));
      chk("t6 m 70..78", mflat(), exp_m(70));
      chk("t6 in_ready", 72'(in_ready), 72'(1));
      idle();
      chk("t6 drained", 72'(out_valid), 72'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
